fxp_alu: RTL and testbench

FXP_ALU -- requirements
Module: fxp_alu

---
 rtl/fxp_alu.sv | 112 +++++++++++
 tb/tb_fxp_alu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fxp_alu.sv
// Two-stage signed fixed-point ALU: ADD, SUB, MUL and MAC with overflow detection.
// Define FXP_ALU_SATURATE_EN to clamp out-of-range results; by default they wrap.
module fxp_alu #(
  parameter int wholeWidth    = 16,
  parameter int fractionWidth = 16
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  calculate_en,
  input  logic [1:0]                            opcode,
  input  logic                                  acc_clear,
  input  logic [wholeWidth+fractionWidth-1:0]   valueOne,
  input  logic [wholeWidth+fractionWidth-1:0]   valueTwo,
  output logic [wholeWidth+fractionWidth-1:0]   result,
  output logic                                  result_valid,
  output logic                                  overflow
);

  localparam int W = wholeWidth + fractionWidth;
  localparam int X = 2 * W + 1;

  localparam logic [1:0] OpAdd = 2'd0;
  localparam logic [1:0] OpSub = 2'd1;
  localparam logic [1:0] OpMul = 2'd2;
  localparam logic [1:0] OpMac = 2'd3;

  logic         s1Valid;
  logic         s1Clear;
  logic [1:0]   s1Op;
  logic [W-1:0] s1A;
  logic [W-1:0] s1B;
  logic [W-1:0] acc;

  logic [2*W-1:0] aWide;
  logic [2*W-1:0] bWide;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prodShift;
  logic [X-1:0]   aExt;
  logic [X-1:0]   bExt;
  logic [X-1:0]   accExt;
  logic [X-1:0]   prodExt;
  logic [X-1:0]   exact;
  logic           isMac;
  logic           ovf;
  logic [W-1:0]   clipped;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1Clear <= 1'b0;
      s1Op    <= OpAdd;
      s1A     <= '0;
      s1B     <= '0;
    end else begin
      s1Valid <= calculate_en;
      s1Clear <= acc_clear;
      s1Op    <= opcode;
      s1A     <= valueOne;
      s1B     <= valueTwo;
    end
  end

  // Everything is evaluated exactly at X bits, wide enough for acc + product.
  always_comb begin
    aWide     = {{W{s1A[W-1]}}, s1A};
    bWide     = {{W{s1B[W-1]}}, s1B};
    prod      = aWide * bWide;
    prodShift = $signed(prod) >>> fractionWidth;
    aExt      = {{(X-W){s1A[W-1]}}, s1A};
    bExt      = {{(X-W){s1B[W-1]}}, s1B};
    accExt    = s1Clear ? '0 : {{(X-W){acc[W-1]}}, acc};
    prodExt   = {prodShift[2*W-1], prodShift};
    isMac     = (s1Op == OpMac);
    exact     = '0;
    case (s1Op)
      OpAdd:   exact = aExt + bExt;
      OpSub:   exact = aExt - bExt;
      OpMul:   exact = prodExt;
      default: exact = accExt + prodExt;
    endcase
    ovf = !((&exact[X-1:W-1]) || !(|exact[X-1:W-1]));
`ifdef FXP_ALU_SATURATE_EN
    if (ovf)
      clipped = exact[X-1] ? {1'b1, {(W-1){1'b0}}}
                           : {1'b0, {(W-1){1'b1}}};
    else
      clipped = exact[W-1:0];
`else
    clipped = exact[W-1:0];
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      acc          <= '0;
    end else begin
      result_valid <= s1Valid;
      if (s1Valid) begin
        result   <= clipped;
        overflow <= ovf;
      end
      if (s1Valid && isMac)
        acc <= clipped;
      else if (s1Clear)
        acc <= '0;
    end
  end

endmodule

// File: tb/tb_fxp_alu.sv
// Directed-vector bench for fxp_alu at Q16.16.
// Expected values follow FXP_ALU_SATURATE_EN when it is defined.
module tb_fxp_alu;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_MAC = 2'd3;

`ifdef FXP_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [31:0] MAXP = 32'h7FFF_FFFF;
  localparam logic [31:0] MINN = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        calculate_en;
  logic [1:0]  opcode;
  logic        acc_clear;
  logic [31:0] valueOne;
  logic [31:0] valueTwo;
  logic [31:0] result;
  logic        result_valid;
  logic        overflow;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  fxp_alu #(.wholeWidth(16), .fractionWidth(16)) dut (
    .clock(clock),
    .reset(reset),
    .calculate_en(calculate_en),
    .opcode(opcode),
    .acc_clear(acc_clear),
    .valueOne(valueOne),
    .valueTwo(valueTwo),
    .result(result),
    .result_valid(result_valid),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic clr);
    calculate_en = en;
    opcode       = op;
    valueOne     = a;
    valueTwo     = b;
    acc_clear    = clr;
  endtask

  task automatic checkOut(input string name, input logic v,
                          input logic [31:0] r, input logic ov);
    check({name, " valid"}, {31'b0, result_valid}, {31'b0, v});
    check({name, " result"}, result, r);
    check({name, " overflow"}, {31'b0, overflow}, {31'b0, ov});
  endtask

  task automatic runOp(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic clr,
                       input logic [31:0] expR, input logic expOv,
                       input string name);
    @(negedge clock);
    drive(1'b1, op, a, b, clr);
    @(negedge clock);
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
    check({name, " lat1 valid"}, {31'b0, result_valid}, 32'h0);
    @(negedge clock);
    checkOut(name, 1'b1, expR, expOv);
    @(negedge clock);
    checkOut({name, " hold"}, 1'b0, expR, expOv);
  endtask

  initial begin
    vecs[0] = '{OP_ADD, 32'h0001_8000, 32'h0002_4000, 32'h0003_C000, 1'b0};
    vecs[1] = '{OP_SUB, 32'h0001_0000, 32'h0002_8000, 32'hFFFE_8000, 1'b0};
    vecs[2] = '{OP_MUL, 32'h0001_8000, 32'hFFFE_0000, 32'hFFFD_0000, 1'b0};
    vecs[3] = '{OP_ADD, 32'h7FFF_0000, 32'h0001_0000,
                SAT ? MAXP : 32'h8000_0000, 1'b1};
    vecs[4] = '{OP_SUB, 32'h8000_0000, 32'h0000_0001,
                SAT ? MINN : 32'h7FFF_FFFF, 1'b1};
    vecs[5] = '{OP_MUL, 32'h0100_0000, 32'h0100_0000,
                SAT ? MAXP : 32'h0000_0000, 1'b1};
    vecs[6] = '{OP_MUL, 32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_FFFF, 1'b0};
    vecs[7] = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0};
    vecs[8] = '{OP_MUL, 32'h8000_0000, 32'hFFFF_0000,
                SAT ? MAXP : 32'h8000_0000, 1'b1};

    reset = 1'b1;
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clock);
    checkOut("reset", 1'b0, 32'h0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0,
            vecs[i].r, vecs[i].ov, $sformatf("vec%0d", i));

    // Back-to-back SUB then MUL
    @(negedge clock);
    drive(1'b1, OP_SUB, 32'h0001_0000, 32'h0002_8000, 1'b0);
    @(negedge clock);
    drive(1'b1, OP_MUL, 32'h0001_8000, 32'hFFFE_0000, 1'b0);
    @(negedge clock);
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
    checkOut("b2b sub", 1'b1, 32'hFFFE_8000, 1'b0);
    @(negedge clock);
    checkOut("b2b mul", 1'b1, 32'hFFFD_0000, 1'b0);
    @(negedge clock);
    check("b2b idle valid", {31'b0, result_valid}, 32'h0);

    // Three MACs, clear on the first
    @(negedge clock);
    drive(1'b1, OP_MAC, 32'h0000_8000, 32'h0004_0000, 1'b1);
    @(negedge clock);
    drive(1'b1, OP_MAC, 32'h0000_8000, 32'h0004_0000, 1'b0);
    @(negedge clock);
    checkOut("mac1", 1'b1, 32'h0002_0000, 1'b0);
    @(negedge clock);
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
    checkOut("mac2", 1'b1, 32'h0004_0000, 1'b0);
    @(negedge clock);
    checkOut("mac3", 1'b1, 32'h0006_0000, 1'b0);

    // Non-MAC op must leave the accumulator alone
    runOp(OP_ADD, 32'h0001_0000, 32'h0001_0000, 1'b0,
          32'h0002_0000, 1'b0, "add mid");

    // MAC, then standalone clear, then MAC
    @(negedge clock);
    drive(1'b1, OP_MAC, 32'h0000_8000, 32'h0004_0000, 1'b0);
    @(negedge clock);
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1);
    @(negedge clock);
    drive(1'b1, OP_MAC, 32'h0001_0000, 32'h0001_0000, 1'b0);
    checkOut("mac before clr", 1'b1, 32'h0008_0000, 1'b0);
    @(negedge clock);
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
    checkOut("clr slot", 1'b0, 32'h0008_0000, 1'b0);
    @(negedge clock);
    checkOut("mac after clr", 1'b1, 32'h0001_0000, 1'b0);

    // Accumulator overflow keeps the written value
    @(negedge clock);
    drive(1'b1, OP_MAC, 32'h7FFF_0000, 32'h0001_0000, 1'b1);
    @(negedge clock);
    drive(1'b1, OP_MAC, 32'h0001_0000, 32'h0001_0000, 1'b0);
    @(negedge clock);
    drive(1'b1, OP_MAC, 32'h0000_0000, 32'h0000_0000, 1'b0);
    checkOut("macov1", 1'b1, 32'h7FFF_0000, 1'b0);
    @(negedge clock);
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
    checkOut("macov2", 1'b1, SAT ? MAXP : 32'h8000_0000, 1'b1);
    @(negedge clock);
    checkOut("macov3", 1'b1, SAT ? MAXP : 32'h8000_0000, 1'b0);

    // Reset one cycle after an accepted op
    @(negedge clock);
    drive(1'b1, OP_MAC, 32'h0001_0000, 32'h0001_0000, 1'b0);
    @(negedge clock);
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOut("rst mid", 1'b0, 32'h0, 1'b0);
    drive(1'b1, OP_MAC, 32'h0000_8000, 32'h0004_0000, 1'b0);
    @(negedge clock);
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
    checkOut("rst drop", 1'b0, 32'h0, 1'b0);
    @(negedge clock);
    checkOut("rst mac", 1'b1, 32'h0002_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
